// File: rtl/hdx_pkg.sv
// rtl/hdx_pkg.sv - shared types and constants for the half-duplex direction controller
//
// Contents:
//   hdx_state_t  - controller FSM state encoding
//   DIR_FWD/REV  - values of the buffer direction select
//   OWN_*        - values of the round-robin last-owner flag
//   is_turn()    - true for either dead-time turnaround state
package hdx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_REV    = 3'd2,
        ST_TURN_F = 3'd3,
        ST_TURN_R = 3'd4
    } hdx_state_t;

    localparam logic DIR_FWD      = 1'b1;
    localparam logic DIR_REV      = 1'b0;

    localparam logic OWN_SENDER   = 1'b0;
    localparam logic OWN_RECEIVER = 1'b1;

    function automatic logic is_turn(input hdx_state_t s);
        return (s == ST_TURN_F) || (s == ST_TURN_R);
    endfunction

endpackage

// File: rtl/hdx_turn_timer.sv
// rtl/hdx_turn_timer.sv - loadable 4-bit down-counter timing the turnaround dead period
//
// Ports:
//   clk    in  clock
//   rst_n  in  synchronous active-low reset
//   start  in  load the counter (asserted on the edge that enters a turn state)
//   run    in  a turn state is currently active; counter clears when low
//   done   out last dead cycle of the turn is in progress
module hdx_turn_timer #(
    parameter int TURN_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic done
);

    // Loading TURN_CYC-1 makes the turn state last exactly TURN_CYC cycles:
    // done is seen while the count sits at zero in the final dead cycle.
    localparam logic [3:0] LOAD_VAL = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (start) begin
            r_cnt <= LOAD_VAL;
        end else if (!run) begin
            r_cnt <= 4'd0;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign done = run && (r_cnt == 4'd0);

endmodule

// File: rtl/half_duplex_dir_ctrl.sv
// rtl/half_duplex_dir_ctrl.sv - half-duplex link arbiter and direction control for the bidirectional buffer
//
// Ports:
//   clk          in  clock
//   rst_n        in  synchronous active-low reset
//   s_req/s_data in  sender-side request and data bit
//   r_req/r_data in  receiver-side request and data bit
//   s_gnt/r_gnt  out side owning the link this cycle
//   sender_port  out buffer direction, 1 = sender->receiver
//   sender_in    out s_data gated by s_gnt
//   reciever_in  out r_data gated by r_gnt
//   busy         out controller not idle
module half_duplex_dir_ctrl
    import hdx_pkg::*;
#(
    parameter int TURN_CYC  = 2,
    parameter int MAX_HOLD  = 16,
    parameter bit RESET_DIR = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_req,
    input  logic s_data,
    output logic s_gnt,
    input  logic r_req,
    input  logic r_data,
    output logic r_gnt,
    output logic sender_port,
    output logic sender_in,
    output logic reciever_in,
    output logic busy
);

    // With no dead time the turn states are bypassed entirely.
    localparam hdx_state_t ST_TO_FWD = (TURN_CYC == 0) ? ST_FWD : ST_TURN_F;
    localparam hdx_state_t ST_TO_REV = (TURN_CYC == 0) ? ST_REV : ST_TURN_R;

    // The counter holds (cycles granted - 1), so the last permitted cycle
    // is the one where it equals MAX_HOLD-1; it never counts past that.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    hdx_state_t r_state;
    hdx_state_t w_state_nxt;

    logic       r_s_gnt;
    logic       r_r_gnt;
    logic       r_busy;
    logic       r_sender_port;
    logic       r_last_owner;
    logic [7:0] r_hold_cnt;

    logic       w_hold_hit;
    logic       w_s_wins;
    logic       w_turn_start;
    logic       w_turn_run;
    logic       w_turn_done;

    assign w_hold_hit = (r_hold_cnt == HOLD_LAST);

    // Sender wins unless the receiver also asks and the sender owned it last.
    assign w_s_wins   = s_req && (!r_req || (r_last_owner == OWN_RECEIVER));

    assign w_turn_start = is_turn(w_state_nxt) && (w_state_nxt != r_state);
    assign w_turn_run   = is_turn(r_state);

    hdx_turn_timer #(
        .TURN_CYC (TURN_CYC)
    ) u_turn_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_turn_start),
        .run   (w_turn_run),
        .done  (w_turn_done)
    );

    // State register; grants and busy are registered from the next state so
    // the gating below sees clean flop outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s_gnt <= 1'b0;
            r_r_gnt <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s_gnt <= (w_state_nxt == ST_FWD);
            r_r_gnt <= (w_state_nxt == ST_REV);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_s_wins) begin
                    w_state_nxt = (r_sender_port == DIR_FWD) ? ST_FWD : ST_TO_FWD;
                end else if (r_req) begin
                    w_state_nxt = (r_sender_port == DIR_REV) ? ST_REV : ST_TO_REV;
                end
            end
            ST_FWD: begin
                if (!s_req) begin
                    w_state_nxt = r_req ? ST_TO_REV : ST_IDLE;
                end else if (w_hold_hit && r_req) begin
                    w_state_nxt = ST_TO_REV;
                end
            end
            ST_REV: begin
                if (!r_req) begin
                    w_state_nxt = s_req ? ST_TO_FWD : ST_IDLE;
                end else if (w_hold_hit && s_req) begin
                    w_state_nxt = ST_TO_FWD;
                end
            end
            ST_TURN_F: begin
                if (w_turn_done) begin
                    w_state_nxt = s_req ? ST_FWD : ST_IDLE;
                end
            end
            ST_TURN_R: begin
                if (w_turn_done) begin
                    w_state_nxt = r_req ? ST_REV : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Direction, round-robin owner and hold counter. The direction flips on
    // the edge that enters the turn, so it is settled for every dead cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sender_port <= RESET_DIR;
            r_last_owner  <= OWN_RECEIVER;
            r_hold_cnt    <= 8'd0;
        end else begin
            if ((w_state_nxt == ST_FWD) || (w_state_nxt == ST_TURN_F)) begin
                r_sender_port <= DIR_FWD;
            end else if ((w_state_nxt == ST_REV) || (w_state_nxt == ST_TURN_R)) begin
                r_sender_port <= DIR_REV;
            end

            if (w_state_nxt == ST_FWD) begin
                r_last_owner <= OWN_SENDER;
            end else if (w_state_nxt == ST_REV) begin
                r_last_owner <= OWN_RECEIVER;
            end

            // Hitting the limit with nobody waiting restarts the hold window.
            if ((w_state_nxt != r_state) || w_hold_hit) begin
                r_hold_cnt <= 8'd0;
            end else if ((r_state == ST_FWD) || (r_state == ST_REV)) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    // Output logic
    always_comb begin
        s_gnt       = r_s_gnt;
        r_gnt       = r_r_gnt;
        busy        = r_busy;
        sender_port = r_sender_port;
        sender_in   = s_data & r_s_gnt;
        reciever_in = r_data & r_r_gnt;
    end

endmodule

// File: doc/half_duplex_dir_ctrl.md
# half_duplex_dir_ctrl

Direction controller and arbiter that sits directly upstream of the bidirectional buffer. It arbitrates between a sender-side and a receiver-side transmit request, drives the buffer's `sender_port` direction select, and gates the data inputs `sender_in` and `reciever_in`. Turnarounds always include a programmable dead period with both data lines forced low, so the buffer never passes stale data across a direction change. It also enforces a maximum hold time so that neither side can starve the other.

## Interface
- `TURN_CYC`, default 2: dead cycles on every direction change; range 0..15, where 0 means an immediate switch.
- `MAX_HOLD`, default 16: maximum consecutive granted cycles for one side while the other side is requesting; range 1..255.
- `RESET_DIR`, default 1: value of `sender_port` after reset (1 = sender→receiver).

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `s_req` input 1: sender side wants to transmit.
- `s_data` input 1: sender-side data bit.
- `s_gnt` output 1: sender side owns the link this cycle.
- `r_req` input 1: receiver side wants to transmit.
- `r_data` input 1: receiver-side data bit.
- `r_gnt` output 1: receiver side owns the link this cycle.
- `sender_port` output 1: buffer direction; 1 = forward (sender→receiver), 0 = reverse.
- `sender_in` output 1: to the buffer; equals `s_data & s_gnt`.
- `reciever_in` output 1: to the buffer; equals `r_data & r_gnt`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- The FSM has five states: IDLE, FWD, REV, TURN_F and TURN_R.
- **Outputs decoded from state:**
  - `s_gnt` is high only in FWD.
  - `r_gnt` is high only in REV.
  - `sender_port` is a register: set to 1 on entry to TURN_F or FWD, set to 0 on entry to TURN_R or REV, and held in IDLE.
- **Round-robin:** the `last_owner` flag resets to "receiver", so the sender wins the first tie. The flag updates on every entry to FWD or REV.
- **IDLE:**
  - The winning requester goes to FWD or REV if `sender_port` already matches its direction.
  - Otherwise it goes to TURN_F or TURN_R.
  - With no request, the FSM stays in IDLE.
- **FWD (REV is symmetric):** a hold counter increments each cycle.
  - `s_req` low and `r_req` high → TURN_R.
  - `s_req` low and `r_req` low → IDLE.
  - Hold counter reaches `MAX_HOLD` with `r_req` high → TURN_R, even if `s_req` is still high.
  - Hold counter reaches `MAX_HOLD` with `r_req` low → the counter clears and the FSM stays in FWD.
- **TURN_F / TURN_R:**
  - Both grants are low and both data outputs are 0.
  - A turn counter runs for exactly `TURN_CYC` cycles, then the FSM enters FWD or REV.
  - If the target requester has dropped by then, the FSM enters IDLE instead; `sender_port` keeps its new value.
  - A turn is never aborted mid-way.
- **`TURN_CYC` = 0:** TURN states are skipped and the FSM transitions straight to the target state.
- **Width rules:** the turn counter is 4 bits and the hold counter is 8 bits. Both clear on every state change and saturate at compare; they never wrap.

## Timing
- Reset values on `rst_n` low at an edge:
  - State IDLE; `s_gnt`, `r_gnt`, `sender_in`, `reciever_in` and `busy` are all 0.
  - `sender_port` = `RESET_DIR`; both counters 0; `last_owner` = receiver.
- Reset asserted mid-transfer or mid-turn overrides everything at that edge; there is no drain.
- Grant latency:
  - Request sampled at edge k with no turn needed → grant high from edge k+1.
  - With a turn → grant high from edge k+1+`TURN_CYC`.
- `sender_port` changes at the same edge as entry to the TURN state, so it is stable for all `TURN_CYC` dead cycles before data flows.
- Data gating is combinational from the registered grant. There is zero added latency, and the data outputs are glitch-free relative to `clk`.
- A grant drops at the edge after its request is sampled low. The requester must not assume the final cycle is granted unless `s_gnt` or `r_gnt` was high.

## Structure
- Shared package `hdx_pkg` contains:
  - The state enum `hdx_state_t`.
  - Direction constants `DIR_FWD` = 1 and `DIR_REV` = 0.
  - Owner constants `OWN_SENDER` and `OWN_RECEIVER`.
- One sub-module, `hdx_turn_timer`: a loadable 4-bit down-counter with `start` and `done` signals, parameterised by `TURN_CYC`, reused for both turn directions.
- The hold counter and FSM live in the top module.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with both requests high → all outputs 0, `sender_port`=1, `busy`=0.
- **Forward without turn:** `s_req`=1, `s_data`=1 from cycle 5 → `s_gnt`=1 and `sender_in`=1 from cycle 6; `sender_port` stays 1; drop `s_req` → IDLE next cycle.
- **Reverse with turn:** `r_req`=1 while `sender_port`=1, `TURN_CYC`=2 → `sender_port`=0 at the next edge; 2 cycles with both data outputs at 0; `r_gnt`=1 on the 3rd cycle.
- **Tie and fairness:** both requests high from IDLE after reset → sender granted first. With `MAX_HOLD`=4 and both requests held high → grant alternates: 4 cycles FWD, 2 turn cycles, 4 cycles REV, repeating.
- **Requester drops during turn:** `r_req` pulses for 1 cycle → full 2-cycle turn completes, then IDLE with `sender_port`=0 and no grant.
- **Reset mid-turn:** `rst_n`=0 during TURN_R → next cycle is IDLE with `sender_port`=1, no grants, and counters 0.
